// File: rtl/gravsim_pkg.sv
// Shared definitions for the gravity-simulator frame control path.
// Holds the USB keycode defaults used as sim_control parameter defaults,
// the control FSM state type, the camera shift saturation bound and the
// saturating shift helper.
package gravsim_pkg;

    // USB HID keycodes
    localparam logic [7:0] KC_SPACE = 8'd44;
    localparam logic [7:0] KC_STEP  = 8'd17;  // N
    localparam logic [7:0] KC_UP    = 8'd26;  // W
    localparam logic [7:0] KC_DOWN  = 8'd22;  // S
    localparam logic [7:0] KC_LEFT  = 8'd4;   // A
    localparam logic [7:0] KC_RIGHT = 8'd7;   // D
    localparam logic [7:0] KC_ZIN   = 8'd20;  // Q
    localparam logic [7:0] KC_ZOUT  = 8'd8;   // E
    localparam logic [7:0] KC_HOME  = 8'd21;  // R

    localparam logic signed [31:0] SHIFT_LIMIT_DEF = 32'sd1023;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_LOW = 2'd1,
        RUN      = 2'd2
    } ctrl_state_t;

    // val + delta in 33 bits, with both the incoming value and the result
    // held to [-limit, +limit].
    function automatic logic signed [31:0] shift_clamp(
        input logic signed [31:0] val,
        input logic signed [31:0] delta,
        input logic signed [31:0] limit
    );
        logic signed [32:0] lim;
        logic signed [32:0] op;
        logic signed [32:0] dl;
        logic signed [32:0] sum;
        lim = {limit[31], limit};
        op  = {val[31], val};
        dl  = {delta[31], delta};
        if (op > lim)
            op = lim;
        else if (op < -lim)
            op = -lim;
        sum = op + dl;
        if (sum > lim)
            sum = lim;
        else if (sum < -lim)
            sum = -lim;
        return sum[31:0];
    endfunction

endpackage

// File: rtl/sync_rise_detect.sv
// Two-flop synchroniser followed by a rising-edge detector.
// Ports:
//   CLK   - sampling clock
//   RESET - synchronous active-high reset, clears all flops
//   d     - asynchronous input
//   rise  - high for one CLK cycle per rising edge of d
module sync_rise_detect (
    input  logic CLK,
    input  logic RESET,
    input  logic d,
    output logic rise
);

    logic s1_q, s2_q, s3_q;
    logic s1_d, s2_d, s3_d;

    always_comb begin
        s1_d = d;
        s2_d = s1_q;
        s3_d = s2_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

    assign rise = s2_q & ~s3_q;

endmodule

// File: rtl/sim_control.sv
// Frame-level control stage ahead of avalon_interface.
// Turns the USB keycode and VGA vertical sync into the physics FSM start
// pulse, pause / single-step state and camera pan/zoom offsets. Owns the
// start/done handshake so only one physics step is in flight at a time;
// frames arriving while a step is in flight are counted as overruns.
// Ports:
//   CLK, RESET        - 50 MHz clock, synchronous active-high reset
//   VGA_VS            - vertical sync, asynchronous to CLK
//   keycode           - current key, 0 = none
//   FSM_DONE          - physics step complete (level)
//   FSM_START         - one-cycle start pulse
//   PAUSED, busy      - pause state, step in flight
//   relative_shift_*  - signed camera offsets
//   overrun_count     - saturating skipped-frame count
//   frame_count       - wrapping VS rising-edge count
module sim_control
    import gravsim_pkg::*;
#(
    parameter logic [7:0]         KEY_SPACE   = KC_SPACE,
    parameter logic [7:0]         KEY_STEP    = KC_STEP,
    parameter logic [7:0]         KEY_UP      = KC_UP,
    parameter logic [7:0]         KEY_DOWN    = KC_DOWN,
    parameter logic [7:0]         KEY_LEFT    = KC_LEFT,
    parameter logic [7:0]         KEY_RIGHT   = KC_RIGHT,
    parameter logic [7:0]         KEY_ZIN     = KC_ZIN,
    parameter logic [7:0]         KEY_ZOUT    = KC_ZOUT,
    parameter logic [7:0]         KEY_HOME    = KC_HOME,
    parameter logic signed [31:0] SHIFT_STEP  = 32'sd1,
    parameter logic signed [31:0] SHIFT_LIMIT = SHIFT_LIMIT_DEF
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               VGA_VS,
    input  logic [7:0]         keycode,
    input  logic               FSM_DONE,
    output logic               FSM_START,
    output logic               PAUSED,
    output logic               busy,
    output logic signed [31:0] relative_shift_x,
    output logic signed [31:0] relative_shift_y,
    output logic signed [31:0] relative_shift_z,
    output logic [7:0]         overrun_count,
    output logic [15:0]        frame_count
);

    logic vs_rise;

    sync_rise_detect u_vs_sync (
        .CLK   (CLK),
        .RESET (RESET),
        .d     (VGA_VS),
        .rise  (vs_rise)
    );

    ctrl_state_t        state_q, state_d;
    logic [7:0]         key_prev_q, key_prev_d;
    logic               start_q, start_d;
    logic               paused_q, paused_d;
    logic               step_req_q, step_req_d;
    logic signed [31:0] x_q, x_d, y_q, y_d, z_q, z_d;
    logic [7:0]         overrun_q, overrun_d;
    logic [15:0]        frame_q, frame_d;

    logic space_press, step_press;

    // Press = first cycle the key appears; holding it does not re-trigger.
    assign space_press = (keycode == KEY_SPACE) && (key_prev_q != KEY_SPACE);
    assign step_press  = (keycode == KEY_STEP)  && (key_prev_q != KEY_STEP);

    always_comb begin
        state_d    = state_q;
        key_prev_d = keycode;
        start_d    = 1'b0;
        // Toggle and step request both look at the pre-toggle pause state.
        paused_d   = paused_q ^ space_press;
        step_req_d = step_req_q | (step_press & paused_q);
        x_d        = x_q;
        y_d        = y_q;
        z_d        = z_q;
        overrun_d  = overrun_q;
        frame_d    = frame_q;

        case (state_q)
            IDLE: begin
                if (vs_rise && (!paused_q || step_req_q)) begin
                    start_d    = 1'b1;
                    state_d    = WAIT_LOW;
                    // A new press this same cycle re-arms for the next frame.
                    step_req_d = step_press & paused_q;
                end
            end
            // DONE may still be high from the previous step; wait for it to
            // drop before accepting a rising DONE as completion.
            WAIT_LOW: if (!FSM_DONE) state_d = RUN;
            RUN:      if (FSM_DONE)  state_d = IDLE;
            default:  state_d = IDLE;
        endcase

        if (vs_rise) begin
            frame_d = frame_q + 16'd1;
            if (state_q != IDLE && overrun_q != 8'hFF)
                overrun_d = overrun_q + 8'd1;

            if (keycode == KEY_HOME) begin
                x_d = '0;
                y_d = '0;
                z_d = '0;
            end else if (keycode == KEY_RIGHT) begin
                x_d = shift_clamp(x_q, SHIFT_STEP, SHIFT_LIMIT);
            end else if (keycode == KEY_LEFT) begin
                x_d = shift_clamp(x_q, -SHIFT_STEP, SHIFT_LIMIT);
            end else if (keycode == KEY_UP) begin
                y_d = shift_clamp(y_q, SHIFT_STEP, SHIFT_LIMIT);
            end else if (keycode == KEY_DOWN) begin
                y_d = shift_clamp(y_q, -SHIFT_STEP, SHIFT_LIMIT);
            end else if (keycode == KEY_ZIN) begin
                z_d = shift_clamp(z_q, SHIFT_STEP, SHIFT_LIMIT);
            end else if (keycode == KEY_ZOUT) begin
                z_d = shift_clamp(z_q, -SHIFT_STEP, SHIFT_LIMIT);
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q    <= IDLE;
            key_prev_q <= '0;
            start_q    <= 1'b0;
            paused_q   <= 1'b0;
            step_req_q <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            overrun_q  <= '0;
            frame_q    <= '0;
        end else begin
            state_q    <= state_d;
            key_prev_q <= key_prev_d;
            start_q    <= start_d;
            paused_q   <= paused_d;
            step_req_q <= step_req_d;
            x_q        <= x_d;
            y_q        <= y_d;
            z_q        <= z_d;
            overrun_q  <= overrun_d;
            frame_q    <= frame_d;
        end
    end

    assign FSM_START        = start_q;
    assign PAUSED           = paused_q;
    assign busy             = (state_q != IDLE);
    assign relative_shift_x = x_q;
    assign relative_shift_y = y_q;
    assign relative_shift_z = z_q;
    assign overrun_count    = overrun_q;
    assign frame_count      = frame_q;

endmodule

// File: tb/tb_sim_control.sv
module tb_sim_control;

    localparam int K_SPACE = 44, K_STEP = 17, K_UP = 26, K_DOWN = 22;
    localparam int K_LEFT = 4, K_RIGHT = 7, K_ZIN = 20, K_ZOUT = 8, K_HOME = 21;
    localparam int LIM = 1023;

    logic               CLK = 1'b0;
    logic               RESET = 1'b1;
    logic               VGA_VS = 1'b0;
    logic [7:0]         keycode = 8'd0;
    logic               FSM_DONE = 1'b0;
    logic               FSM_START, PAUSED, busy;
    logic signed [31:0] sx, sy, sz;
    logic [7:0]         overrun_count;
    logic [15:0]        frame_count;

    sim_control dut (
        .CLK              (CLK),
        .RESET            (RESET),
        .VGA_VS           (VGA_VS),
        .keycode          (keycode),
        .FSM_DONE         (FSM_DONE),
        .FSM_START        (FSM_START),
        .PAUSED           (PAUSED),
        .busy             (busy),
        .relative_shift_x (sx),
        .relative_shift_y (sy),
        .relative_shift_z (sz),
        .overrun_count    (overrun_count),
        .frame_count      (frame_count)
    );

    always #10 CLK = ~CLK;

    int total = 0;
    int bad   = 0;
    int starts = 0;

    // ---------------- reference model (event level, integer arithmetic) ----
    bit vs_hist[3];        // VS as sampled on the last three edges, [0] newest
    int m_prevkey;
    bit m_paused, m_step, m_busy, m_low_seen, m_start;
    int m_x, m_y, m_z, m_frames, m_over;

    function automatic int clampi(int v);
        if (v > LIM)  return LIM;
        if (v < -LIM) return -LIM;
        return v;
    endfunction

    // Predict the outputs after the next CLK edge from the inputs now applied.
    task automatic model_step();
        bit rise, sp, np, old_paused, old_busy;
        if (RESET) begin
            vs_hist = '{0, 0, 0};
            m_prevkey = 0; m_paused = 0; m_step = 0; m_busy = 0;
            m_low_seen = 0; m_start = 0;
            m_x = 0; m_y = 0; m_z = 0; m_frames = 0; m_over = 0;
            return;
        end
        // VS is seen two edges after sampling, and only on a 0->1 change.
        rise = vs_hist[1] && !vs_hist[2];
        sp = (int'(keycode) == K_SPACE) && (m_prevkey != K_SPACE);
        np = (int'(keycode) == K_STEP)  && (m_prevkey != K_STEP);
        old_paused = m_paused;
        old_busy   = m_busy;
        m_start    = 0;
        if (rise) begin
            m_frames = (m_frames + 1) % 65536;
            if (old_busy) begin
                if (m_over < 255) m_over++;
            end else if (!old_paused || m_step) begin
                m_start = 1;
                m_step  = 0;
            end
            case (int'(keycode))
                K_HOME:  begin m_x = 0; m_y = 0; m_z = 0; end
                K_RIGHT: m_x = clampi(m_x + 1);
                K_LEFT:  m_x = clampi(m_x - 1);
                K_UP:    m_y = clampi(m_y + 1);
                K_DOWN:  m_y = clampi(m_y - 1);
                K_ZIN:   m_z = clampi(m_z + 1);
                K_ZOUT:  m_z = clampi(m_z - 1);
                default: ;
            endcase
        end
        // A step completes only on DONE high after DONE has been seen low.
        if (old_busy) begin
            if (!m_low_seen) begin
                if (!FSM_DONE) m_low_seen = 1;
            end else if (FSM_DONE) begin
                m_busy = 0;
            end
        end
        if (m_start) begin
            m_busy = 1;
            m_low_seen = 0;
        end
        if (np && old_paused) m_step = 1;
        if (sp) m_paused = !m_paused;
        vs_hist[2] = vs_hist[1];
        vs_hist[1] = vs_hist[0];
        vs_hist[0] = VGA_VS;
        m_prevkey  = int'(keycode);
    endtask

    task automatic chk(input string nm, input longint act, input longint exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock: predict, let the edge happen, compare just after it.
    task automatic tick();
        model_step();
        @(posedge CLK);
        #1;
        chk("FSM_START", FSM_START, m_start);
        chk("PAUSED", PAUSED, m_paused);
        chk("busy", busy, m_busy);
        chk("shift_x", sx, m_x);
        chk("shift_y", sy, m_y);
        chk("shift_z", sz, m_z);
        chk("overrun_count", overrun_count, m_over);
        chk("frame_count", frame_count, m_frames);
        if (FSM_START) starts++;
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        repeat (2) tick();
        RESET = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) begin
            VGA_VS = 1'b1; repeat (4) tick();
            VGA_VS = 1'b0; repeat (4) tick();
        end
    endtask

    typedef struct {
        logic [7:0] key;
        int         n;
        int         ex, ey, ez;
    } shift_vec_t;

    shift_vec_t tbl[9];
    int keys[10] = '{0, K_SPACE, K_STEP, K_UP, K_DOWN, K_LEFT, K_RIGHT, K_ZIN, K_ZOUT, K_HOME};

    initial begin
        int s0;

        tbl[0] = '{8'd7,  1100,  1023,  0,  0};
        tbl[1] = '{8'd21, 1,     0,     0,  0};
        tbl[2] = '{8'd4,  1030, -1023,  0,  0};
        tbl[3] = '{8'd26, 5,    -1023,  5,  0};
        tbl[4] = '{8'd22, 7,    -1023, -2,  0};
        tbl[5] = '{8'd8,  1025, -1023, -2, -1023};
        tbl[6] = '{8'd20, 3,    -1023, -2, -1020};
        tbl[7] = '{8'd99, 2,    -1023, -2, -1020};
        tbl[8] = '{8'd21, 1,     0,     0,  0};

        // Reset state
        do_reset();
        chk("rst FSM_START", FSM_START, 0);
        chk("rst PAUSED", PAUSED, 0);
        chk("rst busy", busy, 0);
        chk("rst frame_count", frame_count, 0);
        chk("rst shift_x", sx, 0);

        // First frame: start pulse on the third edge after VS is sampled high
        VGA_VS = 1'b1;
        tick(); chk("lat e1 start", FSM_START, 0);
        tick(); chk("lat e2 start", FSM_START, 0);
        tick(); chk("lat e3 start", FSM_START, 1);
        chk("lat busy", busy, 1);
        chk("lat frame_count", frame_count, 1);
        tick(); chk("pulse width", FSM_START, 0);
        VGA_VS = 1'b0;
        chk("busy in RUN", busy, 1);
        FSM_DONE = 1'b1;
        tick(); chk("busy falls", busy, 0);

        // Pause: hold SPACE 5 cycles toggles once, then frames do not start
        do_reset();
        FSM_DONE = 1'b1;
        keycode = 8'(K_SPACE); repeat (5) tick();
        keycode = 8'd0; tick();
        chk("paused after hold", PAUSED, 1);
        s0 = starts;
        frames(3);
        chk("paused starts", starts - s0, 0);
        chk("paused frame_count", frame_count, 3);

        // Single step while paused
        keycode = 8'(K_STEP); tick();
        keycode = 8'd0; tick();
        s0 = starts;
        frames(2);
        chk("single step starts", starts - s0, 1);
        FSM_DONE = 1'b0; tick();
        FSM_DONE = 1'b1; tick();
        chk("step done busy", busy, 0);
        s0 = starts;
        frames(1);
        chk("step_req consumed", starts - s0, 0);

        // Overruns while DONE stays low
        do_reset();
        FSM_DONE = 1'b1;
        s0 = starts;
        frames(1);
        FSM_DONE = 1'b0;
        frames(3);
        chk("overrun count", overrun_count, 3);
        chk("overrun starts", starts - s0, 1);

        // Shift saturation table
        do_reset();
        FSM_DONE = 1'b0;
        for (int i = 0; i < 9; i++) begin
            keycode = tbl[i].key;
            frames(tbl[i].n);
            chk($sformatf("tbl%0d x", i), sx, tbl[i].ex);
            chk($sformatf("tbl%0d y", i), sy, tbl[i].ey);
            chk($sformatf("tbl%0d z", i), sz, tbl[i].ez);
            if (i == 0) begin
                chk("overrun saturate", overrun_count, 255);
                chk("frames 1100", frame_count, 1100);
            end
        end

        // Reset mid-step while paused with nonzero shifts
        keycode = 8'(K_SPACE); tick();
        keycode = 8'(K_RIGHT);
        frames(2);
        chk("pre-rst paused", PAUSED, 1);
        chk("pre-rst busy", busy, 1);
        chk("pre-rst x", sx, 2);
        RESET = 1'b1; VGA_VS = 1'b1;
        tick();
        chk("mid-rst busy", busy, 0);
        chk("mid-rst PAUSED", PAUSED, 0);
        chk("mid-rst x", sx, 0);
        chk("mid-rst overrun", overrun_count, 0);
        s0 = starts;
        repeat (4) tick();
        chk("no start in reset", starts - s0, 0);
        RESET = 1'b0; VGA_VS = 1'b0; keycode = 8'd0;
        tick();

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 5) == 0) begin
                int r;
                r = int'($urandom_range(0, 10));
                keycode = (r == 10) ? 8'($urandom_range(1, 255)) : 8'(keys[r]);
            end
            if ($urandom_range(0, 2) == 0) VGA_VS = ~VGA_VS;
            if ($urandom_range(0, 3) == 0) FSM_DONE = ~FSM_DONE;
            RESET = ($urandom_range(0, 399) == 0);
            tick();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
